// File: rtl/mul_cell_sequencer.sv
// mul_cell_sequencer
// Builds a full 32x32 -> 64-bit product, signed or unsigned, from four partial
// products. The partial products come from one shared 16x16 unsigned
// multiplier cell. The cell is registered and clock-enabled, and it returns
// each product MUL_LATENCY cycles after the operands are issued.
//
// Signed operands are handled by preloading the accumulator with a correction
// term. The four partial products are then accumulated as if the operands
// were unsigned. The sum wraps modulo 2^64, so the correction produces the
// two's-complement product.
//
// MUL_LATENCY must be in the range 1..3.

module mul_cell_sequencer #(
   parameter int MUL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic        busy,
   output logic [15:0] mul_a,
   output logic [15:0] mul_b,
   output logic        mul_en,
   input  logic [31:0] mul_p
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [1:0]  issue_cnt;
   logic [63:0] acc;
   logic [63:0] result_q;

   // Valid/index pipeline that runs alongside the cell's own pipeline. Its
   // last stage says which partial product is on mul_p this cycle.
   logic [MUL_LATENCY-1:0] pipe_vld;
   logic [1:0]             pipe_idx [MUL_LATENCY];

   logic        accept;
   logic        issue_fire;
   logic        cap_vld;
   logic [1:0]  cap_idx;
   logic        last_cap;
   logic [31:0] corr_a_term;
   logic [31:0] corr_b_term;
   logic [63:0] corr;
   logic [63:0] acc_init;
   logic [63:0] term;
   logic [63:0] acc_sum;

   assign accept     = in_valid && (state == IDLE);
   assign issue_fire = (state == ISSUE);
   assign cap_vld    = pipe_vld[MUL_LATENCY-1];
   assign cap_idx    = pipe_idx[MUL_LATENCY-1];
   assign last_cap   = cap_vld && (cap_idx == 2'd3);

   // Compute the signed correction and align the partial product now on mul_p.
   // For each operand whose sign bit is set, subtract the other operand
   // shifted up by 32 bits.
   always_comb begin
      corr_a_term = (in_a[31] && in_signed) ? in_b : 32'd0;
      corr_b_term = (in_b[31] && in_signed) ? in_a : 32'd0;
      corr        = {32'd0, corr_a_term} + {32'd0, corr_b_term};
      acc_init    = 64'd0 - (corr << 32);
      term        = 64'd0;
      case (cap_idx)
         2'd0:    term = {32'd0, mul_p};
         2'd1:    term = {16'd0, mul_p, 16'd0};
         2'd2:    term = {16'd0, mul_p, 16'd0};
         default: term = {mul_p, 32'd0};
      endcase
      acc_sum = acc + (cap_vld ? term : 64'd0);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic. DRAIN ends on the capture of the last partial product.
   // It does not use a cycle count.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)              state_next = ISSUE;
         ISSUE:   if (issue_cnt == 2'd3)   state_next = DRAIN;
         DRAIN:   if (last_cap)            state_next = DONE;
         default: if (out_ready)           state_next = IDLE;
      endcase
   end

   // Output logic. Issue k selects A high with bit 1 and B high with bit 0.
   // The order is (aL,bL), (aL,bH), (aH,bL), (aH,bH).
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
      mul_en    = (state == ISSUE) || (state == DRAIN);
      mul_a     = 16'd0;
      mul_b     = 16'd0;
      if (state == ISSUE) begin
         mul_a = issue_cnt[1] ? a_q[31:16] : a_q[15:0];
         mul_b = issue_cnt[0] ? b_q[31:16] : b_q[15:0];
      end
   end

   assign out_result = result_q;

   // Latch operands and preload the accumulator on accept. Otherwise add each
   // partial product as it arrives. The result register keeps its value after
   // the handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         acc       <= 64'd0;
         issue_cnt <= 2'd0;
         result_q  <= 64'd0;
      end else begin
         if (accept) begin
            a_q       <= in_a;
            b_q       <= in_b;
            acc       <= acc_init;
            issue_cnt <= 2'd0;
         end else begin
            acc <= acc_sum;
            if (issue_fire) issue_cnt <= issue_cnt + 2'd1;
         end
         if ((state == DRAIN) && last_cap) result_q <= acc_sum;
      end
   end

   // Shift the issue tag through a pipeline MUL_LATENCY stages deep. This
   // matches the cell's pipeline because mul_en stays high for the whole of
   // ISSUE and DRAIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld <= '0;
         for (int i = 0; i < MUL_LATENCY; i++) pipe_idx[i] <= 2'd0;
      end else begin
         pipe_vld[0] <= issue_fire;
         pipe_idx[0] <= issue_cnt;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
         end
      end
   end

endmodule

// File: doc/mul_cell_sequencer.md
Name: mul_cell_sequencer

Overview:
- Multi-cycle controller that computes a full 32x32 -> 64-bit product by time-sharing one external 16x16 unsigned hardware multiplier cell (registered, clock-enabled, fixed pipeline latency).
- Sits between the CPU execute-stage custom/extended-multiply path and a single DSP multiplier, for full-width (mulxuu/mulxss-style) results without spending three or four DSP cells.
- Valid/ready handshake on both the operand and result sides.

Parameters:
- MUL_LATENCY, 1, cycles from operands presented with mul_en high to the product on mul_p; legal range 1..3.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  sequencer can accept operands.
- in_a  in  32  multiplicand.
- in_b  in  32  multiplier.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  out  1  out_result is valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  64  product.
- busy  out  1  high in every state except IDLE.
- mul_a  out  16  operand A to the multiplier cell.
- mul_b  out  16  operand B to the multiplier cell.
- mul_en  out  1  clock enable to the multiplier cell; advances its pipeline.
- mul_p  in  32  unsigned 16x16 product from the cell, MUL_LATENCY cycles after issue.

Behaviour:
- Reset values:
  - in_ready=1; out_valid=0; busy=0; out_result=0; mul_a=0; mul_b=0; mul_en=0; accumulator, counters and state cleared.
  - Reset mid-operation discards the operation. There is no partial output.
- States: IDLE -> ISSUE (4 cycles) -> DRAIN (MUL_LATENCY cycles) -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept edge = cycle 0), latch in_a, in_b, in_signed and go to ISSUE.
  - Initialise the accumulator to the sign correction (mod 2^64): -(((a[31]&s)?b:0) + ((b[31]&s)?a:0)) << 32.
- ISSUE, cycles 1..4:
  - mul_en=1. Issue index k=0..3: (aL,bL), (aL,bH), (aH,bL), (aH,bH).
  - Shift applied to each product: 0, 16, 16, 32.
- DRAIN:
  - mul_en stays 1 with mul_a=mul_b=0, so the cell pipeline advances.
  - Leave for DONE after the product of k=3 is accumulated.
- Accumulation:
  - The product of issue k appears on mul_p in cycle 1+k+MUL_LATENCY.
  - It is added, shifted, into the 64-bit accumulator at the end of that cycle.
  - Capture uses a MUL_LATENCY-deep valid/index shift register, not the state.
  - All adds are mod 2^64; carries out of bit 63 are dropped.
- DONE:
  - out_valid=1 from cycle 5+MUL_LATENCY; out_result = accumulator.
  - mul_en=0; mul_a=mul_b=0.
  - Hold out_valid and out_result stable until out_valid&out_ready, then go to IDLE.
  - out_result keeps its last value after the handshake.
- in_ready is asserted only in IDLE, so in_valid while busy is ignored.
- Minimum operation period is 6+MUL_LATENCY cycles, with back-to-back requests and out_ready tied high.
- in_a/in_b/in_signed changes after the accept edge have no effect.
- Outside ISSUE/DRAIN: mul_en=0 and mul_a=mul_b=0.

Test Plan:
- Unsigned, MUL_LATENCY=1: in_a=in_b=0xFFFFFFFF, in_signed=0, out_ready=1 -> out_result=0xFFFFFFFE00000001, out_valid asserted exactly in cycle 6, mul_en high cycles 1..5.
- Signed, in_signed=1:
  - 0xFFFFFFFF x 0xFFFFFFFF -> 0x0000000000000001.
  - 0x80000000 x 0x00000002 -> 0xFFFFFFFF00000000.
  - 0x80000000 x 0x80000000 -> 0x4000000000000000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0, mul_en=0. Release -> one handshake, then in_ready=1 the next cycle.
- Busy rejection: pulse in_valid with different operands during ISSUE -> ignored, first result unaffected. Second request accepted only after the result handshake, and its result is correct.
- Reset mid-ISSUE (cycle 2) -> next edge gives state IDLE, out_valid=0, mul_en=0, out_result=0. After deassert, a fresh 3x5 (unsigned) yields 15.
- MUL_LATENCY=3, unsigned 0x12345678 x 0x9ABCDEF0 -> out_result=0x0B00EA4E242D2080, out_valid in cycle 8, mul_en high cycles 1..7.
